// File: rtl/ram_arb_2to1_if.sv
// Host-side req/gnt/rvalid bus of the RAM arbiter.
// The master modport is the host; the slave modport is the arbiter port.
interface ram_arb_2to1_if;
    logic        req;
    logic        gnt;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, err, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, err, rdata
    );
endinterface

// File: rtl/ram_arb_2to1.sv
// Two-host round-robin arbiter and sequencer in front of a 1-cycle single-port RAM.
// It can zero-fill the RAM after reset, and it answers out-of-window addresses with an error.
module ram_arb_2to1 #(
    parameter int unsigned Depth        = 16384,
    parameter logic [31:0] BaseAddr     = 32'h0000_0000,
    parameter bit          ClearOnReset = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    ram_arb_2to1_if.slave      h0,
    ram_arb_2to1_if.slave      h1,
    output logic               ram_req_o,
    output logic               ram_we_o,
    output logic [3:0]         ram_be_o,
    output logic [31:0]        ram_addr_o,
    output logic [31:0]        ram_wdata_o,
    input  logic               ram_rvalid_i,
    input  logic [31:0]        ram_rdata_i,
    output logic               init_done_o
);

    localparam int unsigned CntW  = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [32:0] WinLo = {1'b0, BaseAddr};
    localparam logic [32:0] WinHi = WinLo + 33'(Depth) * 33'd4;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e          r_state;
    logic [CntW-1:0] r_clr_cnt;
    logic            r_last;
    logic            r_resp_valid;
    logic            r_owner;
    logic            r_err;
    logic            r_we;

    logic            w_run;
    logic            w_init;
    logic            w_in0;
    logic            w_in1;
    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_any;
    logic            w_in_range;
    logic            w_sel_we;
    logic [3:0]      w_sel_be;
    logic [31:0]     w_sel_addr;
    logic [31:0]     w_sel_wdata;
    logic            w_rvalid;
    logic            w_rdata_ok;

    // Reset gates every output, so nothing leaks out while rst_ni is low in either mode.
    assign w_run  = rst_ni && (r_state == S_RUN);
    assign w_init = rst_ni && (r_state == S_INIT);

    // 33-bit window compare so that BaseAddr + 4*Depth cannot wrap.
    assign w_in0 = ({1'b0, h0.addr} >= WinLo) && ({1'b0, h0.addr} < WinHi);
    assign w_in1 = ({1'b0, h1.addr} >= WinLo) && ({1'b0, h1.addr} < WinHi);

    // Round-robin: under contention the host that was not granted last wins.
    assign w_gnt0 = w_run && h0.req && (!h1.req || r_last);
    assign w_gnt1 = w_run && h1.req && (!h0.req || !r_last);
    assign w_any  = w_gnt0 || w_gnt1;

    assign w_in_range  = w_gnt1 ? w_in1    : w_in0;
    assign w_sel_we    = w_gnt1 ? h1.we    : h0.we;
    assign w_sel_be    = w_gnt1 ? h1.be    : h0.be;
    assign w_sel_addr  = w_gnt1 ? h1.addr  : h0.addr;
    assign w_sel_wdata = w_gnt1 ? h1.wdata : h0.wdata;

    assign h0.gnt      = w_gnt0;
    assign h1.gnt      = w_gnt1;
    assign init_done_o = w_run;

    // RAM command: the clear sweep during INIT, otherwise the in-window winner.
    always_comb begin
        ram_req_o   = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'h0;
        ram_addr_o  = 32'h0;
        ram_wdata_o = 32'h0;
        if (w_init) begin
            ram_req_o  = 1'b1;
            ram_we_o   = 1'b1;
            ram_be_o   = 4'hF;
            ram_addr_o = 32'({r_clr_cnt, 2'b00});
        end else if (w_any && w_in_range) begin
            ram_req_o   = 1'b1;
            ram_we_o    = w_sel_we;
            ram_be_o    = w_sel_be;
            ram_addr_o  = w_sel_addr - BaseAddr;
            ram_wdata_o = w_sel_wdata;
        end
    end

    // Route the single outstanding response to its owner; errors need no RAM beat.
    assign w_rvalid   = r_resp_valid && (r_err || ram_rvalid_i);
    assign w_rdata_ok = w_rvalid && !r_err && !r_we;

    assign h0.rvalid = w_rvalid && !r_owner;
    assign h1.rvalid = w_rvalid &&  r_owner;
    assign h0.err    = r_resp_valid && r_err && !r_owner;
    assign h1.err    = r_resp_valid && r_err &&  r_owner;
    assign h0.rdata  = (w_rdata_ok && !r_owner) ? ram_rdata_i : 32'h0;
    assign h1.rdata  = (w_rdata_ok &&  r_owner) ? ram_rdata_i : 32'h0;

    // Sequencer state, clear counter, fairness pointer and response tracking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            if (ClearOnReset) begin
                r_state <= S_INIT;
            end else begin
                r_state <= S_RUN;
            end
            r_clr_cnt    <= '0;
            r_last       <= 1'b1;
            r_resp_valid <= 1'b0;
            r_owner      <= 1'b0;
            r_err        <= 1'b0;
            r_we         <= 1'b0;
        end else begin
            if (r_state == S_INIT) begin
                r_clr_cnt <= r_clr_cnt + CntW'(1);
                if (r_clr_cnt == CntW'(Depth - 1)) begin
                    r_state <= S_RUN;
                end
            end
            r_resp_valid <= w_any;
            if (w_any) begin
                r_owner <= w_gnt1;
                r_err   <= !w_in_range;
                r_we    <= w_sel_we;
                r_last  <= w_gnt1;
            end
        end
    end

endmodule
